// File: rtl/gpu_ready_ctrl_if.sv
// Command-push and engine-handshake bundle between the Nios side and gpu_ready_ctrl.
// master = system/engine side, slave = gpu_ready_ctrl.
interface gpu_ready_ctrl_if;
   logic        cmd_valid;
   logic [31:0] cmd_data;
   logic        cmd_ready;
   logic        eng_start;
   logic [31:0] eng_cmd;
   logic        eng_done;

   modport master (
      output cmd_valid, cmd_data, eng_done,
      input  cmd_ready, eng_start, eng_cmd
   );

   modport slave (
      input  cmd_valid, cmd_data, eng_done,
      output cmd_ready, eng_start, eng_cmd
   );
endinterface

// File: rtl/gpu_ready_ctrl.sv
// Command FIFO feeding a GPU engine, with busy timeout and a registered gpu_ready level for Nios polling.
// Optional GPU_READY_VSYNC_WAIT_EN: commands with bit 31 set are held until the next vsync rising edge.
module gpu_ready_ctrl #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 65535
) (
   input  logic             clk,
   input  logic             reset,
   gpu_ready_ctrl_if.slave  bus,
   input  logic             vsync,
   input  logic             err_clr,
   output logic             gpu_ready,
   output logic             err_timeout
);

   localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
   localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

`ifdef GPU_READY_VSYNC_WAIT_EN
   typedef enum logic [1:0] {IDLE, WAIT_VS, START, BUSY} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, BUSY} state_t;
`endif

   state_t        state, state_nxt;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_nxt;
   logic [31:0]   busy_cnt, busy_nxt;
   logic [31:0]   eng_cmd_q;
   logic [31:0]   head;
   logic          eng_start_q;
   logic          push, pop, err_set;

`ifdef GPU_READY_VSYNC_WAIT_EN
   logic          vs_prev;
`else
   logic          unused_vsync;
   assign unused_vsync = vsync;
`endif

   assign bus.cmd_ready = (count < DEPTH_C);
   assign bus.eng_start = eng_start_q;
   assign bus.eng_cmd   = eng_cmd_q;
   assign head          = mem[rd_ptr];

   always_comb begin
      push      = bus.cmd_valid && bus.cmd_ready;
      pop       = 1'b0;
      err_set   = 1'b0;
      state_nxt = state;
      busy_nxt  = busy_cnt;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop       = 1'b1;
               state_nxt = START;
`ifdef GPU_READY_VSYNC_WAIT_EN
               if (head[31]) state_nxt = WAIT_VS;
`endif
            end
         end
`ifdef GPU_READY_VSYNC_WAIT_EN
         WAIT_VS: begin
            if (vsync && !vs_prev) state_nxt = START;
         end
`endif
         START: begin
            state_nxt = BUSY;
            busy_nxt  = '0;
         end
         BUSY: begin
            // Completion takes priority over a timeout landing on the same cycle.
            if (bus.eng_done) begin
               state_nxt = IDLE;
               busy_nxt  = '0;
            end else if (TIMEOUT_C != 32'd0 && (busy_cnt + 32'd1) == TIMEOUT_C) begin
               state_nxt = IDLE;
               err_set   = 1'b1;
               busy_nxt  = '0;
            end else begin
               busy_nxt  = busy_cnt + 32'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   end

   // Storage carries no reset; validity is tracked by count and the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.cmd_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         busy_cnt    <= '0;
         eng_start_q <= 1'b0;
         eng_cmd_q   <= '0;
         err_timeout <= 1'b0;
         gpu_ready   <= 1'b1;
`ifdef GPU_READY_VSYNC_WAIT_EN
         vs_prev     <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         busy_cnt    <= busy_nxt;
         eng_start_q <= (state_nxt == START);
         gpu_ready   <= (state_nxt == IDLE) && (count_nxt == '0);
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            eng_cmd_q <= head;
         end
         if (err_set)      err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
`ifdef GPU_READY_VSYNC_WAIT_EN
         vs_prev     <= vsync;
`endif
      end
   end

endmodule

// File: tb/tb_gpu_ready_ctrl.sv
// Directed bench for gpu_ready_ctrl (DEPTH=4, TIMEOUT=10); inputs change and outputs are sampled 1ns after each rising edge.
module tb_gpu_ready_ctrl;

   logic clk = 1'b0;
   logic reset;
   logic vsync;
   logic err_clr;
   logic gpu_ready;
   logic err_timeout;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] b_cmds [4];

   gpu_ready_ctrl_if bus ();

   gpu_ready_ctrl #(.DEPTH(4), .TIMEOUT(10)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .vsync       (vsync),
      .err_clr     (err_clr),
      .gpu_ready   (gpu_ready),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Push one command in the current cycle; returns in the following cycle.
   task automatic push_cmd(input logic [31:0] d);
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = d;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = '0;
   endtask

   initial begin
      reset         = 1'b1;
      vsync         = 1'b0;
      err_clr       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = '0;
      bus.eng_done  = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      chk("rst_gpu_ready", {31'd0, gpu_ready}, 32'd1);
      chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rst_eng_start", {31'd0, bus.eng_start}, 32'd0);
      chk("rst_eng_cmd", bus.eng_cmd, 32'd0);
      chk("rst_err", {31'd0, err_timeout}, 32'd0);

      // Single command latency: push at N.
      push_cmd(32'h0000_0123);                       // now N+1
      chk("lat_gpu_ready_n1", {31'd0, gpu_ready}, 32'd0);
      chk("lat_no_start_n1", {31'd0, bus.eng_start}, 32'd0);
      tick();                                        // N+2
      chk("lat_start_n2", {31'd0, bus.eng_start}, 32'd1);
      chk("lat_cmd_n2", bus.eng_cmd, 32'h0000_0123);
      tick();                                        // N+3
      chk("lat_start_n3", {31'd0, bus.eng_start}, 32'd0);
      tick(); tick(); tick(); tick();                // N+7: done 5 cycles after start
      bus.eng_done = 1'b1;
      chk("lat_busy_ready", {31'd0, gpu_ready}, 32'd0);
      tick();
      bus.eng_done = 1'b0;
      chk("lat_done_ready", {31'd0, gpu_ready}, 32'd1);

      // Fill while the engine is stalled on A0; fifth push must be dropped.
      b_cmds[0] = 32'h0000_00B1;
      b_cmds[1] = 32'h0000_00B2;
      b_cmds[2] = 32'h0000_00B3;
      b_cmds[3] = 32'h0000_00B4;
      push_cmd(32'h0000_00A0);
      tick();
      chk("fill_a0_start", {31'd0, bus.eng_start}, 32'd1);
      chk("fill_a0_cmd", bus.eng_cmd, 32'h0000_00A0);
      tick();                                        // engine now busy
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("fill_cmd_ready_%0d", i), {31'd0, bus.cmd_ready}, (i < 4) ? 32'd1 : 32'd0);
         push_cmd(32'h0000_00B1 + 32'(i));
      end
      chk("fill_full", {31'd0, bus.cmd_ready}, 32'd0);
      bus.eng_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.eng_done = 1'b0;
         chk($sformatf("drain_ready_%0d", i), {31'd0, gpu_ready}, 32'd0);
         tick();
         chk($sformatf("drain_start_%0d", i), {31'd0, bus.eng_start}, 32'd1);
         chk($sformatf("drain_cmd_%0d", i), bus.eng_cmd, b_cmds[i]);
         tick();
         bus.eng_done = 1'b1;
      end
      tick();
      bus.eng_done = 1'b0;
      chk("drain_empty_ready", {31'd0, gpu_ready}, 32'd1);
      tick();
      chk("drain_no_b5_start", {31'd0, bus.eng_start}, 32'd0);
      chk("drain_no_b5_cmd", bus.eng_cmd, 32'h0000_00B4);

      // Timeout: start at S, IDLE with error at S+11.
      push_cmd(32'h0000_00C0);
      tick();                                        // S
      chk("to_start", {31'd0, bus.eng_start}, 32'd1);
      for (int i = 0; i < 10; i++) tick();           // S+10
      chk("to_err_before", {31'd0, err_timeout}, 32'd0);
      chk("to_ready_before", {31'd0, gpu_ready}, 32'd0);
      tick();                                        // S+11
      chk("to_err_set", {31'd0, err_timeout}, 32'd1);
      chk("to_ready_after", {31'd0, gpu_ready}, 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("to_err_clr", {31'd0, err_timeout}, 32'd0);

      // Done on the exact timeout cycle wins.
      push_cmd(32'h0000_00D0);
      tick();
      for (int i = 0; i < 10; i++) tick();           // S+10
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      chk("race_err", {31'd0, err_timeout}, 32'd0);
      chk("race_ready", {31'd0, gpu_ready}, 32'd1);
      bus.eng_done = 1'b1;                           // stray done in IDLE
      tick();
      bus.eng_done = 1'b0;
      chk("idle_done_ready", {31'd0, gpu_ready}, 32'd1);
      chk("idle_done_start", {31'd0, bus.eng_start}, 32'd0);
      tick();
      chk("idle_done_cmd", bus.eng_cmd, 32'h0000_00D0);

      // Timeout set and err_clr in the same cycle: set wins.
      push_cmd(32'h0000_00E0);
      tick();
      for (int i = 0; i < 9; i++) tick();            // S+9
      err_clr = 1'b1;
      tick();
      tick();                                        // S+11
      err_clr = 1'b0;
      chk("setclr_err", {31'd0, err_timeout}, 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("setclr_cleared", {31'd0, err_timeout}, 32'd0);

      // Vsync-wait flag.
      push_cmd(32'h8000_0001);                       // N+1
`ifdef GPU_READY_VSYNC_WAIT_EN
      tick();                                        // N+2
      chk("vs_hold_n2", {31'd0, bus.eng_start}, 32'd0);
      tick(); tick();
      chk("vs_hold_n4", {31'd0, bus.eng_start}, 32'd0);
      vsync = 1'b1;
      tick();
      chk("vs_start", {31'd0, bus.eng_start}, 32'd1);
      chk("vs_cmd", bus.eng_cmd, 32'h8000_0001);
`else
      tick();                                        // N+2
      chk("vs_start", {31'd0, bus.eng_start}, 32'd1);
      chk("vs_cmd", bus.eng_cmd, 32'h8000_0001);
`endif
      tick();
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      vsync = 1'b0;
      chk("vs_done_ready", {31'd0, gpu_ready}, 32'd1);

      // Reset while busy with two commands queued.
      push_cmd(32'h0000_00F0);
      tick();
      tick();                                        // BUSY
      push_cmd(32'h0000_00F1);
      push_cmd(32'h0000_00F2);
      chk("rb_queued_ready", {31'd0, gpu_ready}, 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rb_gpu_ready", {31'd0, gpu_ready}, 32'd1);
      chk("rb_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rb_eng_cmd", bus.eng_cmd, 32'd0);
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rb_no_start_%0d", i), {31'd0, bus.eng_start}, 32'd0);
         chk($sformatf("rb_idle_ready_%0d", i), {31'd0, gpu_ready}, 32'd1);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
